// File: rtl/gpr_file_sb_if.sv
// Register-file port bundle: two read ports with busy, two write ports, scoreboard mark.
// master drives addresses/writes/marks; slave is the register file.
interface gpr_file_sb_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] sa, sb;
  logic [WIDTH-1:0]  souta, soutb;
  logic              busya, busyb;
  logic [ADDR_W-1:0] sc;
  logic [WIDTH-1:0]  sin;
  logic              sw;
  logic [ADDR_W-1:0] sd;
  logic [WIDTH-1:0]  din;
  logic              dw;
  logic [ADDR_W-1:0] sm;
  logic              smark;

  modport master (
    output sa, sb, sc, sin, sw, sd, din, dw, sm, smark,
    input  souta, soutb, busya, busyb
  );
  modport slave (
    input  sa, sb, sc, sin, sw, sd, din, dw, sm, smark,
    output souta, soutb, busya, busyb
  );
endinterface

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file: 2 read / 2 write ports, same-cycle bypass, per-register busy scoreboard.
// Register 0 is hardwired to zero and never busy.
module gpr_entry #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wc_hit,
  input  logic             wd_hit,
  input  logic             mark_hit,
  input  logic [WIDTH-1:0] sin,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             busy
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      // load port wins a same-address collision
      if (wd_hit)      q <= din;
      else if (wc_hit) q <= sin;
      // a new producer issued as the old one retires keeps the register busy
      if (mark_hit)              busy <= 1'b1;
      else if (wc_hit || wd_hit) busy <= 1'b0;
    end
  end
endmodule

module gpr_file_sb #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         reset,
  gpr_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  wr_t wc, wd;
  assign wc = '{en: bus.sw, addr: bus.sc, data: bus.sin};
  assign wd = '{en: bus.dw, addr: bus.sd, data: bus.din};

  logic [DEPTH-1:0][WIDTH-1:0] rf;
  logic [DEPTH-1:0]            bz;

  assign rf[0] = '0;
  assign bz[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_ent
    gpr_entry #(.WIDTH(WIDTH)) u_ent (
      .clk      (clk),
      .reset    (reset),
      .wc_hit   (wc.en && (wc.addr == ADDR_W'(r))),
      .wd_hit   (wd.en && (wd.addr == ADDR_W'(r))),
      .mark_hit (bus.smark && (bus.sm == ADDR_W'(r))),
      .sin      (wc.data),
      .din      (wd.data),
      .q        (rf[r]),
      .busy     (bz[r])
    );
  end

  logic [1:0][WIDTH-1:0] rd;
  logic [1:0]            rbz;

  // bypass order mirrors write priority so the read equals next-edge contents
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero, hit_c, hit_d, mark;
    assign ra    = (p == 0) ? bus.sa : bus.sb;
    assign zero  = reset || (ra == '0);
    assign hit_c = wc.en && (wc.addr == ra);
    assign hit_d = wd.en && (wd.addr == ra);
    assign mark  = bus.smark && (bus.sm == ra);
    assign rd[p]  = zero  ? '0 :
                    hit_d ? wd.data :
                    hit_c ? wc.data : rf[ra];
    assign rbz[p] = zero ? 1'b0 :
                    ((hit_c || hit_d) && !mark) ? 1'b0 : bz[ra];
  end

  assign bus.souta = rd[0];
  assign bus.soutb = rd[1];
  assign bus.busya = rbz[0];
  assign bus.busyb = rbz[1];
endmodule

// File: tb/tb_gpr_file_sb.sv
// Scoreboard bench for gpr_file_sb: stimulus pushes expected read results, a negedge monitor checks.
module tb_gpr_file_sb;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_file_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  gpr_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic drv(input logic rst,
                     input logic [4:0] sa, input logic [4:0] sb,
                     input logic sw, input logic [4:0] sc, input logic [31:0] sin,
                     input logic dw, input logic [4:0] sd, input logic [31:0] din,
                     input logic smark, input logic [4:0] sm);
    reset     = rst;
    bus.sa    = sa;    bus.sb  = sb;
    bus.sw    = sw;    bus.sc  = sc;  bus.sin = sin;
    bus.dw    = dw;    bus.sd  = sd;  bus.din = din;
    bus.smark = smark; bus.sm  = sm;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic ba, input logic bb);
    exp_t e;
    e.nm = nm; e.a = a; e.b = b; e.ba = ba; e.bb = bb;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: outputs are stable mid-cycle; at most one expectation per cycle
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (bus.souta !== e.a || bus.soutb !== e.b || bus.busya !== e.ba || bus.busyb !== e.bb) begin
          n_bad++;
          $display("FAIL %s: got a=%h b=%h ba=%b bb=%b, want a=%h b=%h ba=%b bb=%b",
                   e.nm, bus.souta, bus.soutb, bus.busya, bus.busyb, e.a, e.b, e.ba, e.bb);
        end
      end
    end
  end

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // outputs forced low while reset is high
    drv(1, 5, 9, 1, 5, 32'h1111_1111, 1, 9, 32'h2222_2222, 0, 0);
    expect_rd("rst_hold", 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 32; i++) begin
      drv(0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0, 0);
      expect_rd($sformatf("post_rst_%0d", i), 0, 0, 0, 0);
      tick();
    end

    drv(0, 5, 0, 1, 5, 32'hAAAA_AAAA, 0, 0, 0, 0, 0);
    expect_rd("byp_c", 32'hAAAA_AAAA, 0, 0, 0);
    tick();
    drv(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("arr_c", 32'hAAAA_AAAA, 0, 0, 0);
    tick();

    drv(0, 0, 5, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    expect_rd("r0_byp", 0, 32'hAAAA_AAAA, 0, 0);
    tick();
    drv(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("r0_arr", 0, 32'hAAAA_AAAA, 0, 0);
    tick();

    drv(0, 10, 10, 1, 10, 32'h5555_5555, 1, 10, 32'h1234_5678, 0, 0);
    expect_rd("coll_byp", 32'h1234_5678, 32'h1234_5678, 0, 0);
    tick();
    drv(0, 10, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("coll_arr", 32'h1234_5678, 32'hAAAA_AAAA, 0, 0);
    tick();

    drv(0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    expect_rd("mark_same", 0, 0, 0, 0);
    tick();
    drv(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("mark_vis", 0, 0, 1, 1);
    tick();
    drv(0, 7, 0, 0, 0, 0, 1, 7, 32'h0000_CAFE, 0, 0);
    expect_rd("ld_retire", 32'h0000_CAFE, 0, 0, 0);
    tick();
    drv(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("retired", 32'h0000_CAFE, 32'h0000_CAFE, 0, 0);
    tick();

    // mark and retire on the same register and edge: mark wins
    drv(0, 0, 0, 1, 7, 32'h0000_BEEF, 0, 0, 0, 1, 7);
    tick();
    drv(0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("mark_beats_clr", 32'h0000_BEEF, 32'h0000_BEEF, 1, 1);
    tick();

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("r0_nobusy", 0, 0, 0, 0);
    tick();

    drv(0, 3, 4, 1, 3, 32'h0000_0033, 1, 4, 32'h0000_0044, 1, 6);
    expect_rd("dual_wr", 32'h0000_0033, 32'h0000_0044, 0, 0);
    tick();
    drv(0, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("pre_rst_busy", 0, 32'h0000_BEEF, 1, 1);
    tick();
    drv(0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("pre_rst_regs", 32'h0000_0033, 32'h0000_0044, 0, 0);
    tick();

    drv(1, 3, 6, 1, 3, 32'h0000_0099, 0, 0, 0, 0, 0);
    expect_rd("rst_mid", 0, 0, 0, 0);
    tick();
    drv(0, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("rst_regs", 0, 0, 0, 0);
    tick();
    drv(0, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_rd("rst_busy", 0, 0, 0, 0);
    tick();

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4 && q.size() != 0; i++) tick();
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
